// File: rtl/fp21_pack_pkg.sv
// FP21 field widths, bias and the stage-1 bundle shared by the FP21 cores.
// Optional build macro used by fp21_pack: FP21_PACK_STATS_EN.
package fp21_pack_pkg;

    localparam int EXP_W   = 9;
    localparam int FRAC_W  = 14;
    localparam int PEXP_W  = 7;
    localparam int MANT_W  = FRAC_W - 1;
    localparam int WORD_W  = 1 + PEXP_W + MANT_W;
    localparam int BIAS    = 63;
    localparam int SIGN_POS = WORD_W - 1;
    localparam int EXP_LSB  = MANT_W;

    localparam logic [PEXP_W-1:0] EXP_INF = '1;

    typedef struct packed {
        logic              sign;
        logic [PEXP_W-1:0] bexp;
        logic [MANT_W-1:0] mant;
        logic              zero;
        logic              ovf;
        logic              unf;
    } s1_t;

endpackage

// File: rtl/fp21_pipe_ctrl.sv
// Two-stage valid/ready enable controller; an empty stage always accepts.
// Reusable by any FP21 core with a two-register pipeline.
module fp21_pipe_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic s1_en,
    output logic s2_en,
    output logic s1_valid,
    output logic s2_valid
);

    assign s2_en    = out_ready | ~s2_valid;
    assign s1_en    = s2_en | ~s1_valid;
    assign in_ready = s1_en;

    // Stage valid bits advance whenever their stage is enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_en) s1_valid <= in_valid;
            if (s2_en) s2_valid <= s1_valid;
        end
    end

endmodule

// File: rtl/fp21_pack.sv
// Packs an unpacked FP21 result into a 21-bit word, flushing and saturating.
// Build macro FP21_PACK_STATS_EN adds overflow/underflow event counters.
module fp21_pack
    import fp21_pack_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [FRAC_W-1:0] frac_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] word_out,
    output logic              flag_ovf,
    output logic              flag_unf,
    output logic              flag_zero
`ifdef FP21_PACK_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       ovf_count,
    output logic [15:0]       unf_count
`endif
);

    localparam int BW = EXP_W + 1;
    localparam logic signed [BW-1:0] BIAS_S = BW'(BIAS);
    localparam logic signed [BW-1:0] EMAX_S = BW'(2**PEXP_W - 1);
    localparam logic signed [BW-1:0] ZERO_S = '0;

    logic s1_en;
    logic s2_en;
    logic s1_valid;
    logic s2_valid;

    fp21_pipe_ctrl u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .out_ready(out_ready),
        .in_ready (in_ready),
        .s1_en    (s1_en),
        .s2_en    (s2_en),
        .s1_valid (s1_valid),
        .s2_valid (s2_valid)
    );

    assign out_valid = s2_valid;

    logic signed [BW-1:0] b;
    logic                 nz;
    s1_t                  s1_d;
    s1_t                  s1_q;

    // Widened add so extreme exponents cannot wrap into range.
    assign b  = $signed({exp_in[EXP_W-1], exp_in}) + BIAS_S;
    assign nz = frac_in[FRAC_W-1];

    // Stage-1 classification of the incoming operand.
    always_comb begin
        s1_d      = '0;
        s1_d.sign = sign_in;
        s1_d.bexp = b[PEXP_W-1:0];
        s1_d.mant = frac_in[MANT_W-1:0];
        s1_d.zero = ~nz;
        s1_d.ovf  = nz & (b >= EMAX_S);
        s1_d.unf  = nz & (b <= ZERO_S);
    end

    // Stage-1 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) s1_q <= '0;
        else if (s1_en) s1_q <= s1_d;
    end

    logic [WORD_W-1:0] word_d;
    logic              ovf_d;
    logic              unf_d;
    logic              zero_d;

    // Stage-2 word assembly; a bubble clears the flags.
    always_comb begin
        word_d = '0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        zero_d = 1'b0;
        if (s1_valid) begin
            word_d[SIGN_POS] = s1_q.sign;
            unique case (1'b1)
                s1_q.zero | s1_q.unf: begin
                    zero_d = 1'b1;
                    unf_d  = s1_q.unf;
                end
                s1_q.ovf: begin
                    word_d[EXP_LSB +: PEXP_W] = EXP_INF;
                    ovf_d = 1'b1;
                end
                default: begin
                    word_d[EXP_LSB +: PEXP_W] = s1_q.bexp;
                    word_d[MANT_W-1:0] = s1_q.mant;
                end
            endcase
        end
    end

    // Stage-2 output register, held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_out  <= '0;
            flag_ovf  <= 1'b0;
            flag_unf  <= 1'b0;
            flag_zero <= 1'b0;
        end else if (s2_en) begin
            word_out  <= word_d;
            flag_ovf  <= ovf_d;
            flag_unf  <= unf_d;
            flag_zero <= zero_d;
        end
    end

`ifdef FP21_PACK_STATS_EN
    logic xfer;
    assign xfer = out_valid & out_ready;

    // Saturating event counters; clear beats increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= '0;
            unf_count <= '0;
        end else if (stats_clr) begin
            ovf_count <= '0;
            unf_count <= '0;
        end else begin
            if (xfer && flag_ovf && ovf_count != 16'hFFFF)
                ovf_count <= ovf_count + 16'd1;
            if (xfer && flag_unf && unf_count != 16'hFFFF)
                unf_count <= unf_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp21_pack.sv
// Directed bench for fp21_pack: single vectors, then a stalled stream with reset.
// Stats checks are compiled in when FP21_PACK_STATS_EN is defined.
module tb_fp21_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign_in = 1'b0;
    logic [8:0]  exp_in = '0;
    logic [13:0] frac_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [20:0] word_out;
    logic        flag_ovf;
    logic        flag_unf;
    logic        flag_zero;
`ifdef FP21_PACK_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] ovf_count;
    logic [15:0] unf_count;
    int          e_ovf = 0;
    int          e_unf = 0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp21_pack dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sign_in  (sign_in),
        .exp_in   (exp_in),
        .frac_in  (frac_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .word_out (word_out),
        .flag_ovf (flag_ovf),
        .flag_unf (flag_unf),
        .flag_zero(flag_zero)
`ifdef FP21_PACK_STATS_EN
        ,
        .stats_clr(stats_clr),
        .ovf_count(ovf_count),
        .unf_count(unf_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // flags packed as {ovf, unf, zero}
    task automatic send(input string tag, input logic s,
                        input logic [8:0] e, input logic [13:0] f,
                        input logic [20:0] ew, input logic [2:0] ef);
        @(negedge clk);
        in_valid = 1'b1;
        sign_in = s;
        exp_in = e;
        frac_in = f;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_word"}, 32'(word_out), 32'(ew));
        chk({tag, "_flags"}, 32'({flag_ovf, flag_unf, flag_zero}), 32'(ef));
    endtask

    logic        vs[8];
    logic [8:0]  ve[8];
    logic [13:0] vf[8];
    logic [20:0] vw[8];
    logic [2:0]  vfl[8];

    logic [23:0] q[$];
    logic [23:0] exp_item;
    logic [20:0] held_word;
    logic        held;
    int          idx;
    int          cyc;

    initial begin
        vs  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        ve  = '{9'd0, 9'd1, 9'd64, -9'sd63, -9'sd62, 9'd5, 9'd63, -9'sd10};
        vf  = '{14'h2000, 14'h3FFF, 14'h2000, 14'h2000,
                14'h2000, 14'h0000, 14'h2ABC, 14'h3001};
        vw  = '{21'h07E000, 21'h181FFF, 21'h0FE000, 21'h000000,
                21'h002000, 21'h100000, 21'h0FCABC, 21'h16B001};
        vfl = '{3'b000, 3'b000, 3'b100, 3'b011,
                3'b000, 3'b001, 3'b000, 3'b000};

        repeat (3) @(negedge clk);
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_word", 32'(word_out), 32'd0);
        chk("rst_flags", 32'({flag_ovf, flag_unf, flag_zero}), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        send("one", 1'b0, 9'd0, 14'h2000, 21'h07E000, 3'b000);
        send("neg", 1'b1, 9'd1, 14'h3FFF, 21'h181FFF, 3'b000);
        send("ovf64", 1'b0, 9'd64, 14'h2000, 21'h0FE000, 3'b100);
        send("ovf255", 1'b0, 9'd255, 14'h2000, 21'h0FE000, 3'b100);
        send("maxn", 1'b0, 9'd63, 14'h2ABC, 21'h0FCABC, 3'b000);
        send("unf63", 1'b0, -9'sd63, 14'h2000, 21'h000000, 3'b011);
        send("minn", 1'b0, -9'sd62, 14'h2000, 21'h002000, 3'b000);
        send("unf256", 1'b1, -9'sd256, 14'h2FFF, 21'h100000, 3'b011);
        send("negz", 1'b1, 9'd200, 14'h0000, 21'h100000, 3'b001);

        @(negedge clk);
        chk("bubble_flags", 32'({out_valid, flag_ovf, flag_unf, flag_zero}),
            32'd0);

`ifdef FP21_PACK_STATS_EN
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        chk("clr_ovf", 32'(ovf_count), 32'd0);
        chk("clr_unf", 32'(unf_count), 32'd0);
`endif

        idx = 0;
        cyc = 0;
        held = 1'b0;
        held_word = '0;
        while ((idx < 8 || q.size() > 0) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 5) begin
                rst = 1'b1;
                in_valid = 1'b0;
                #1;
                chk("midrst_vld", 32'(out_valid), 32'd0);
                q.delete();
                held = 1'b0;
`ifdef FP21_PACK_STATS_EN
                e_ovf = 0;
                e_unf = 0;
`endif
                @(negedge clk);
                rst = 1'b0;
                continue;
            end
            out_ready = 1'($urandom_range(0, 1));
            if (idx < 8) begin
                in_valid = 1'b1;
                sign_in = vs[idx];
                exp_in = ve[idx];
                frac_in = vf[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held)
                chk("hold", 32'({out_valid, word_out}), 32'({1'b1, held_word}));
            held = out_valid && !out_ready;
            held_word = word_out;
            if (in_valid && in_ready) begin
                q.push_back({vfl[idx], vw[idx]});
                idx++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("extra_out", 32'(word_out), 32'h0BAD0000);
                end else begin
                    exp_item = q.pop_front();
                    chk("stream", 32'({flag_ovf, flag_unf, flag_zero, word_out}),
                        32'(exp_item));
`ifdef FP21_PACK_STATS_EN
                    e_ovf += int'(exp_item[23]);
                    e_unf += int'(exp_item[22]);
`endif
                end
            end
        end
        chk("stream_timeout", 32'(cyc < 300), 32'd1);

        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("drained", 32'(out_valid), 32'd0);

`ifdef FP21_PACK_STATS_EN
        chk("cnt_ovf", 32'(ovf_count), 32'(e_ovf));
        chk("cnt_unf", 32'(unf_count), 32'(e_unf));
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        chk("clr2_ovf", 32'(ovf_count), 32'd0);
        chk("clr2_unf", 32'(unf_count), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
